fp_operand_loader: RTL and testbench

FP_OPERAND_LOADER -- requirements
Module: fp_operand_loader

---
 rtl/fp_operand_loader.sv | 153 +++++++++++++++
 tb/tb_fp_operand_loader.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_operand_loader.sv
// Front end for a floating-point adder demo. It collects two operands from slide switches through
// debounced load/clear push-buttons, then signals when both operands are ready.
module fp_operand_loader #(
  parameter int DB_CNT_W = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_load,
  input  logic       btn_clr,
  input  logic [7:0] sw,
  output logic       sign1,
  output logic       sign2,
  output logic [3:0] exp1,
  output logic [3:0] exp2,
  output logic [7:0] frac1,
  output logic [7:0] frac2,
  output logic       valid,
  output logic       start,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    A_EXP  = 3'd0,
    A_FRAC = 3'd1,
    B_EXP  = 3'd2,
    B_FRAC = 3'd3,
    DONE   = 3'd4
  } state_e;

  localparam logic [DB_CNT_W-1:0] CNT_MAX = {DB_CNT_W{1'b1}};
  localparam logic [DB_CNT_W-1:0] CNT_ONE = {{(DB_CNT_W-1){1'b0}}, 1'b1};

  // Bit 0 carries the load button, bit 1 the clear button.
  logic [1:0]          sync1_q, sync1_d;
  logic [1:0]          sync2_q, sync2_d;
  logic [1:0]          db_lvl_q, db_lvl_d;
  logic [DB_CNT_W-1:0] db_cnt_q [2];
  logic [DB_CNT_W-1:0] db_cnt_d [2];
  logic [1:0]          tick_q, tick_d;

  state_e     state_q, state_d;
  logic       sign1_q, sign1_d, sign2_q, sign2_d;
  logic [3:0] exp1_q, exp1_d, exp2_q, exp2_d;
  logic [7:0] frac1_q, frac1_d, frac2_q, frac2_d;
  logic       valid_q, valid_d;
  logic       start_q, start_d;

  always_comb begin
    sync1_d  = {btn_clr, btn_load};
    sync2_d  = sync1_q;
    db_lvl_d = db_lvl_q;
    for (int i = 0; i < 2; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != db_lvl_q[i]) begin
        // The level only flips after a full run of differing samples; the counter then restarts.
        if (db_cnt_q[i] == CNT_MAX) begin
          db_lvl_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + CNT_ONE;
        end
      end
    end
    tick_d = db_lvl_d & ~db_lvl_q;
  end

  always_comb begin
    state_d = state_q;
    sign1_d = sign1_q;
    sign2_d = sign2_q;
    exp1_d  = exp1_q;
    exp2_d  = exp2_q;
    frac1_d = frac1_q;
    frac2_d = frac2_q;
    if (tick_q[1]) begin
      state_d = A_EXP;
    end else if (tick_q[0]) begin
      unique case (state_q)
        A_EXP: begin
          sign1_d = sw[7];
          exp1_d  = sw[3:0];
          state_d = A_FRAC;
        end
        A_FRAC: begin
          frac1_d = {1'b1, sw[6:0]};
          state_d = B_EXP;
        end
        B_EXP: begin
          sign2_d = sw[7];
          exp2_d  = sw[3:0];
          state_d = B_FRAC;
        end
        B_FRAC: begin
          frac2_d = {1'b1, sw[6:0]};
          state_d = DONE;
        end
        DONE:    state_d = A_EXP;
        default: state_d = A_EXP;
      endcase
    end
    // valid and start are decoded from the next state so they line up with the state register.
    valid_d = (state_d == DONE);
    start_d = (state_d == DONE) && (state_q != DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      db_lvl_q <= '0;
      for (int i = 0; i < 2; i++) begin
        db_cnt_q[i] <= '0;
      end
      tick_q   <= '0;
      state_q  <= A_EXP;
      sign1_q  <= 1'b0;
      sign2_q  <= 1'b0;
      exp1_q   <= 4'h0;
      exp2_q   <= 4'h0;
      frac1_q  <= 8'h00;
      frac2_q  <= 8'h00;
      valid_q  <= 1'b0;
      start_q  <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      db_lvl_q <= db_lvl_d;
      for (int i = 0; i < 2; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
      tick_q   <= tick_d;
      state_q  <= state_d;
      sign1_q  <= sign1_d;
      sign2_q  <= sign2_d;
      exp1_q   <= exp1_d;
      exp2_q   <= exp2_d;
      frac1_q  <= frac1_d;
      frac2_q  <= frac2_d;
      valid_q  <= valid_d;
      start_q  <= start_d;
    end
  end

  assign sign1 = sign1_q;
  assign sign2 = sign2_q;
  assign exp1  = exp1_q;
  assign exp2  = exp2_q;
  assign frac1 = frac1_q;
  assign frac2 = frac2_q;
  assign valid = valid_q;
  assign start = start_q;
  assign phase = state_q;

endmodule

// File: tb/tb_fp_operand_loader.sv
// Self-checking bench for fp_operand_loader with a short debounce counter. Button presses are
// compared against an operand-entry model that works in whole presses rather than clock cycles.
module tb_fp_operand_loader;

  logic       clk;
  logic       reset;
  logic       btn_load;
  logic       btn_clr;
  logic [7:0] sw;
  logic       sign1, sign2;
  logic [3:0] exp1, exp2;
  logic [7:0] frac1, frac2;
  logic       valid, start;
  logic [2:0] phase;

  int n_compared;
  int n_mismatched;
  int start_cnt;

  // Reference model: entry step 0..4 plus the two captured operands.
  int         m_step;
  logic       m_sign [2];
  logic [3:0] m_exp  [2];
  logic [7:0] m_frac [2];
  int         m_starts;

  typedef struct {
    logic [7:0] sw;
    logic [2:0] exp_phase;
    logic       exp_valid;
  } vec_t;

  vec_t tbl [4];

  fp_operand_loader #(.DB_CNT_W(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_load (btn_load),
    .btn_clr  (btn_clr),
    .sw       (sw),
    .sign1    (sign1),
    .sign2    (sign2),
    .exp1     (exp1),
    .exp2     (exp2),
    .frac1    (frac1),
    .frac2    (frac2),
    .valid    (valid),
    .start    (start),
    .phase    (phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (start === 1'b1) start_cnt++;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ops_dut();
    return {6'd0, sign1, exp1, frac1, sign2, exp2, frac2};
  endfunction

  function automatic logic [31:0] ops_model();
    return {6'd0, m_sign[0], m_exp[0], m_frac[0], m_sign[1], m_exp[1], m_frac[1]};
  endfunction

  task automatic model_reset();
    m_step = 0;
    for (int i = 0; i < 2; i++) begin
      m_sign[i] = 1'b0;
      m_exp[i]  = 4'h0;
      m_frac[i] = 8'h00;
    end
  endtask

  // Steps 0/1 fill operand A (exponent then fraction), steps 2/3 operand B, step 4 is complete.
  task automatic model_press(input bit ld, input bit cl, input logic [7:0] s);
    int k;
    if (cl) begin
      m_step = 0;
    end else if (ld) begin
      if (m_step == 4) begin
        m_step = 0;
      end else begin
        k = m_step / 2;
        if (m_step % 2 == 0) begin
          m_sign[k] = s[7];
          m_exp[k]  = s[3:0];
        end else begin
          m_frac[k] = {1'b1, s[6:0]};
        end
        m_step++;
        if (m_step == 4) m_starts++;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check_output({tag, "_phase"}, 32'(phase), 32'(m_step));
    check_output({tag, "_valid"}, 32'(valid), 32'(m_step == 4));
    check_output({tag, "_ops"}, ops_dut(), ops_model());
    check_output({tag, "_starts"}, 32'(start_cnt), 32'(m_starts));
  endtask

  // One bouncy press: short bounce, long stable hold, bouncy release, long quiet gap.
  task automatic apply_stimulus(input bit ld, input bit cl, input logic [7:0] s);
    sw = s;
    btn_load = ld; btn_clr = cl; wait_cycles(1);
    btn_load = 0;  btn_clr = 0;  wait_cycles(1);
    btn_load = ld; btn_clr = cl; wait_cycles(10);
    btn_load = 0;  btn_clr = 0;  wait_cycles(1);
    btn_load = ld; btn_clr = cl; wait_cycles(1);
    btn_load = 0;  btn_clr = 0;  wait_cycles(12);
    model_press(ld, cl, s);
  endtask

  task automatic wiggle_sw(input int n);
    for (int i = 0; i < n; i++) begin
      sw = 8'($urandom);
      wait_cycles(1);
    end
  endtask

  initial begin
    int n;
    int starts_before;
    bit ld, cl;
    int r;
    logic [7:0] s;

    n_compared = 0;
    n_mismatched = 0;
    start_cnt = 0;
    m_starts = 0;
    model_reset();

    tbl[0] = '{sw: 8'h85, exp_phase: 3'd1, exp_valid: 1'b0};
    tbl[1] = '{sw: 8'h2A, exp_phase: 3'd2, exp_valid: 1'b0};
    tbl[2] = '{sw: 8'h03, exp_phase: 3'd3, exp_valid: 1'b0};
    tbl[3] = '{sw: 8'h7F, exp_phase: 3'd4, exp_valid: 1'b1};

    reset = 1'b0;
    btn_load = 1'b0;
    btn_clr = 1'b0;
    sw = 8'h00;
    wait_cycles(3);
    check_output("reset_phase", 32'(phase), 32'd0);
    check_output("reset_valid_start", {30'd0, valid, start}, 32'd0);
    check_output("reset_ops", ops_dut(), 32'd0);
    reset = 1'b1;
    wait_cycles(2);

    // Latency from a clean rise to the first phase change.
    sw = 8'h85;
    btn_load = 1'b1;
    n = 0;
    while (n < 30 && phase == 3'd0) begin
      wait_cycles(1);
      n++;
    end
    n_compared++;
    if (n < 6 || n > 8) begin
      n_mismatched++;
      $display("[TB] FAIL tick_latency: got %0d cycles expected 6..8", n);
    end
    if (n < 10) wait_cycles(10 - n);
    btn_load = 1'b0;
    wait_cycles(15);
    model_press(1'b1, 1'b0, 8'h85);
    check_all("single_tick");

    // A three-sample glitch must not get through the debouncer.
    btn_load = 1'b1;
    wait_cycles(3);
    btn_load = 1'b0;
    wait_cycles(12);
    check_all("glitch");

    apply_stimulus(1'b0, 1'b1, 8'($urandom));
    check_all("clr_to_start");

    starts_before = start_cnt;
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b1, 1'b0, tbl[i].sw);
      check_output($sformatf("tbl%0d_phase", i), 32'(phase), 32'(tbl[i].exp_phase));
      check_output($sformatf("tbl%0d_valid", i), 32'(valid), 32'(tbl[i].exp_valid));
      wiggle_sw(3);
    end
    check_output("tbl_ops", ops_dut(), {6'd0, 1'b1, 4'h5, 8'hAA, 1'b0, 4'h3, 8'hFF});
    check_output("tbl_start_pulses", 32'(start_cnt - starts_before), 32'd1);
    check_all("tbl_model");

    wiggle_sw(20);
    check_all("sw_toggle_hold");

    starts_before = start_cnt;
    apply_stimulus(1'b1, 1'b0, 8'h5C);
    check_all("load_in_done");
    check_output("load_in_done_no_start", 32'(start_cnt - starts_before), 32'd0);

    apply_stimulus(1'b1, 1'b0, 8'hB7);
    apply_stimulus(1'b1, 1'b0, 8'h11);
    apply_stimulus(1'b1, 1'b0, 8'hEE);
    check_all("reach_b_frac");
    apply_stimulus(1'b0, 1'b1, 8'h42);
    check_all("clr_in_b_frac");

    apply_stimulus(1'b1, 1'b0, 8'h9A);
    apply_stimulus(1'b1, 1'b0, 8'h64);
    apply_stimulus(1'b1, 1'b1, 8'hF3);
    check_all("load_and_clr");

    // Asynchronous reset in the middle of a debounce while in A_FRAC.
    apply_stimulus(1'b1, 1'b0, 8'hC9);
    check_all("pre_reset");
    btn_load = 1'b1;
    wait_cycles(4);
    #2;
    reset = 1'b0;
    #1;
    check_output("async_rst_phase", 32'(phase), 32'd0);
    check_output("async_rst_flags", {30'd0, valid, start}, 32'd0);
    check_output("async_rst_ops", ops_dut(), 32'd0);
    btn_load = 1'b0;
    wait_cycles(3);
    reset = 1'b1;
    model_reset();
    wait_cycles(2);
    apply_stimulus(1'b1, 1'b0, 8'h36);
    check_all("after_reset");

    for (int i = 0; i < 24; i++) begin
      r  = $urandom_range(0, 5);
      cl = (r <= 1);
      ld = (r != 0);
      s  = 8'($urandom);
      apply_stimulus(ld, cl, s);
      check_all($sformatf("rand%0d", i));
      wiggle_sw($urandom_range(1, 4));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
